// File: rtl/adc_qsys_nios2_gen2_ocimem_pkg.sv
// Shared definitions for the OCI debug-memory controller: jdo field positions,
// FSM state encoding, control-register bit indices and the JTAG request record
// held in the one-deep pending slot.
package adc_qsys_nios2_gen2_ocimem_pkg;

  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WR_ARM    = 35;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_GO        = 34;
  localparam int JDO_CLR_ERR   = 33;

  localparam int CTRL_READY = 0;
  localparam int CTRL_ERROR = 1;
  localparam int CTRL_GO    = 2;
  localparam int CTRL_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_JACC = 2'd1,
    ST_JCAP = 2'd2
  } ocimem_state_e;

  // One JTAG strobe: which strobe it was (a or b) plus the jdo it carried.
  typedef struct packed {
    logic             is_a;
    logic [JDO_W-1:0] jdo;
  } jtag_req_t;

endpackage

// File: rtl/adc_qsys_nios2_gen2_ocimem_ram.sv
// Single-port synchronous debug RAM, 2**ADDR_W x 32 bits.
// Ports: clk; en enables the access; we selects write; addr word address;
//   be byte enables for writes; wdata write data; q read data, valid one
//   clock after an enabled read and held otherwise. Contents are not reset.
module adc_qsys_nios2_gen2_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/adc_qsys_nios2_gen2_ocimem_ctrl.sv
// OCI debug-memory controller. Arbitrates the debug RAM between the JTAG
// strobes (take_action_ocimem_a/b) and the CPU debug slave port, returns JTAG
// read data on MonDReg and keeps the monitor_ready/error/go flags.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   jdo, take_*_ocimem_*         JTAG data and one-cycle strobes
//   cpu_address .. cpu_byteenable CPU request (address MSB selects ctrl reg)
//   cpu_readdata, cpu_readdatavalid, cpu_waitrequest  CPU response
//   MonDReg                      last JTAG read data
//   monitor_ready/error/go       monitor handshake flags
//   dbg_state                    current FSM state
//
// CPU handshake: a request (cpu_read or cpu_write high) is accepted on a rising
// edge where cpu_waitrequest is low; the master holds the request unchanged
// while cpu_waitrequest is high. An accepted read returns cpu_readdata with
// cpu_readdatavalid high for exactly one cycle, the cycle after acceptance.
// cpu_write wins when both cpu_read and cpu_write are high.
module adc_qsys_nios2_gen2_ocimem_ctrl
  import adc_qsys_nios2_gen2_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go,
  output logic [1:0]        dbg_state
);

  ocimem_state_e     state;
  logic [ADDR_W-1:0] addr_ptr;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_data;
  logic              wr_arm;
  logic              acc_we;
  logic              pend_valid;
  jtag_req_t         pend_req;
  logic              ovf;

  // ocimem_a wins over ocimem_b in the same cycle.
  logic      strobe_a, strobe_b, strobe;
  jtag_req_t in_req;
  assign strobe_a = take_action_ocimem_a;
  assign strobe_b = take_action_ocimem_b & ~take_action_ocimem_a;
  assign strobe   = strobe_a | strobe_b;
  assign in_req   = {strobe_a, jdo};

  // Last busy cycle: a read leaves from JCAP, a JTAG write leaves from JACC.
  logic busy, busy_exit;
  assign busy      = (state != ST_IDLE);
  assign busy_exit = (state == ST_JCAP) || (state == ST_JACC && acc_we);

  // Request started this cycle: the pending one takes precedence at exit;
  // a fresh strobe in the exit cycle with an empty slot is started directly.
  logic      serve_valid;
  jtag_req_t serve_req;
  always_comb begin
    serve_valid = 1'b0;
    serve_req   = in_req;
    if (!busy) begin
      serve_valid = strobe;
    end else if (busy_exit) begin
      if (pend_valid) begin
        serve_valid = 1'b1;
        serve_req   = pend_req;
      end else begin
        serve_valid = strobe;
      end
    end
  end

  logic pend_load, pend_drop;
  assign pend_load = strobe && busy && !pend_valid && !busy_exit;
  assign pend_drop = strobe && busy && pend_valid;

  logic [ADDR_W-1:0] serve_addr;
  logic              serve_arm;
  logic [31:0]       serve_wdata;
  logic              unused_jdo_bits;
  assign serve_addr      = serve_req.jdo[JDO_ADDR_LSB +: ADDR_W];
  assign serve_arm       = serve_req.jdo[JDO_WR_ARM];
  assign serve_wdata     = serve_req.jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
  assign unused_jdo_bits = ^{serve_req.jdo[37:36], serve_req.jdo[2:0]};

  // CPU side
  logic cpu_accept, cpu_ctrl_sel, cpu_ctrl_wr, cpu_rd_acc;
  assign cpu_waitrequest = !(state == ST_IDLE && !pend_valid && !strobe);
  assign cpu_accept      = (cpu_read || cpu_write) && !cpu_waitrequest;
  assign cpu_ctrl_sel    = cpu_address[ADDR_W];
  assign cpu_ctrl_wr     = cpu_accept && cpu_write && cpu_ctrl_sel;
  assign cpu_rd_acc      = cpu_accept && !cpu_write;

  // RAM port mux: JTAG owns the RAM during JACC, otherwise an accepted CPU access.
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_q;
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cpu_address[ADDR_W-1:0];
    ram_be    = cpu_byteenable;
    ram_wdata = cpu_writedata;
    if (state == ST_JACC) begin
      ram_en    = 1'b1;
      ram_we    = acc_we;
      ram_addr  = acc_addr;
      ram_be    = 4'hF;
      ram_wdata = acc_data;
    end else if (cpu_accept && !cpu_ctrl_sel) begin
      ram_en = 1'b1;
      ram_we = cpu_write;
    end
  end

  adc_qsys_nios2_gen2_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // JTAG access FSM, pending slot and overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      addr_ptr   <= '0;
      acc_addr   <= '0;
      acc_data   <= '0;
      wr_arm     <= 1'b0;
      acc_we     <= 1'b0;
      pend_valid <= 1'b0;
      pend_req   <= '0;
      ovf        <= 1'b0;
      MonDReg    <= '0;
    end else begin
      if (pend_drop) ovf <= 1'b1;
      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_req   <= in_req;
      end else if (busy_exit && pend_valid) begin
        pend_valid <= 1'b0;
      end

      case (state)
        ST_JACC: if (!acc_we) state <= ST_JCAP;
        ST_JCAP: MonDReg <= ram_q;
        default: ;
      endcase
      if (busy_exit) state <= ST_IDLE;

      // Starting a request overrides the return to IDLE above.
      if (serve_valid) begin
        if (serve_req.is_a) begin
          addr_ptr <= serve_addr;
          wr_arm   <= serve_arm;
          if (!serve_arm) begin
            acc_addr <= serve_addr;
            acc_we   <= 1'b0;
            state    <= ST_JACC;
          end
        end else begin
          acc_addr <= addr_ptr;
          acc_we   <= wr_arm;
          acc_data <= serve_wdata;
          addr_ptr <= addr_ptr + 1'b1;
          state    <= ST_JACC;
        end
      end
    end
  end

  // Monitor flags: CPU effects first, JTAG effects override on conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      monitor_go    <= 1'b0;
    end else begin
      if (cpu_ctrl_wr && cpu_writedata[CTRL_READY]) monitor_ready <= 1'b1;
      if (cpu_ctrl_wr && cpu_writedata[CTRL_ERROR]) monitor_error <= 1'b1;
      if (cpu_ctrl_wr && cpu_writedata[CTRL_GO])    monitor_go    <= 1'b0;
      if (take_no_action_ocimem_a && jdo[JDO_GO]) begin
        monitor_go    <= 1'b1;
        monitor_ready <= 1'b0;
      end
      if (take_no_action_ocimem_a && jdo[JDO_CLR_ERR]) monitor_error <= 1'b0;
    end
  end

  // CPU read response
  logic       rdv_q, rd_ctrl_q;
  logic [3:0] ctrl_snap_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv_q       <= 1'b0;
      rd_ctrl_q   <= 1'b0;
      ctrl_snap_q <= '0;
    end else begin
      rdv_q <= cpu_rd_acc;
      if (cpu_rd_acc) begin
        rd_ctrl_q   <= cpu_ctrl_sel;
        ctrl_snap_q <= {ovf, monitor_go, monitor_error, monitor_ready};
      end
    end
  end

  assign cpu_readdatavalid = rdv_q;
  assign cpu_readdata      = rdv_q ? (rd_ctrl_q ? {28'b0, ctrl_snap_q} : ram_q) : '0;
  assign dbg_state         = state;

  a_strobe_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(take_action_ocimem_a && take_action_ocimem_b));

endmodule

// File: tb/tb_adc_qsys_nios2_gen2_ocimem_ctrl.sv
module tb_adc_qsys_nios2_gen2_ocimem_ctrl;
  import adc_qsys_nios2_gen2_ocimem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [8:0]  cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid, cpu_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, monitor_go;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int rdv_cnt;

  adc_qsys_nios2_gen2_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_byteenable          (cpu_byteenable),
    .cpu_readdata            (cpu_readdata),
    .cpu_readdatavalid       (cpu_readdatavalid),
    .cpu_waitrequest         (cpu_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .monitor_go              (monitor_go),
    .dbg_state               (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic jtag_a(input logic [7:0] addr, input logic arm);
    jdo = '0;
    jdo[JDO_ADDR_LSB +: 8] = addr;
    jdo[JDO_WR_ARM] = arm;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] data);
    jdo = '0;
    jdo[JDO_WDATA_MSB:JDO_WDATA_LSB] = data;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic jtag_na(input logic go, input logic clr);
    jdo = '0;
    jdo[JDO_GO] = go;
    jdo[JDO_CLR_ERR] = clr;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic cpu_wait();
    int n = 0;
    while (cpu_waitrequest && n < 20) begin
      tick();
      n++;
    end
    if (cpu_waitrequest) check("cpu_wait_bound", 32'(cpu_waitrequest), 0);
  endtask

  task automatic cpu_wr(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] be);
    cpu_address = addr;
    cpu_writedata = data;
    cpu_byteenable = be;
    cpu_write = 1'b1;
    #1;
    cpu_wait();
    tick();
    cpu_write = 1'b0;
  endtask

  task automatic cpu_rd_chk(input string tag, input logic [8:0] addr, input logic [31:0] exp);
    cpu_address = addr;
    cpu_read = 1'b1;
    #1;
    cpu_wait();
    tick();
    cpu_read = 1'b0;
    check({tag, "_rdv"}, 32'(cpu_readdatavalid), 1);
    check(tag, cpu_readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    cpu_address = '0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_writedata = '0;
    cpu_byteenable = '0;
    repeat (3) tick();
    check("rst_mondreg", MonDReg, 0);
    check("rst_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 0);
    check("rst_rdv", 32'(cpu_readdatavalid), 0);
    check("rst_readdata", cpu_readdata, 0);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_wait", 32'(cpu_waitrequest), 0);
    reset_n = 1'b1;
    tick();

    // JTAG burst write 1,2,3 at 0x10..0x12, CPU reads back
    jtag_a(8'h10, 1'b1);
    check("arm_stays_idle", 32'(dbg_state), 0);
    jtag_b(32'd1);
    check("jwr_jacc", 32'(dbg_state), 1);
    jtag_b(32'd2);
    jtag_b(32'd3);
    tick();
    check("jwr_idle", 32'(dbg_state), 0);
    check("jwr_mondreg_unchanged", MonDReg, 0);
    cpu_rd_chk("rd_10", 9'h010, 32'd1);
    cpu_rd_chk("rd_11", 9'h011, 32'd2);
    cpu_rd_chk("rd_12", 9'h012, 32'd3);

    // CPU write then JTAG read, MonDReg 2 clocks after the strobe
    cpu_wr(9'h020, 32'hCAFEF00D, 4'hF);
    jtag_a(8'h20, 1'b0);
    check("jrd_state_jacc", 32'(dbg_state), 1);
    tick();
    check("jrd_mondreg_1clk", MonDReg, 0);
    tick();
    check("jrd_mondreg_2clk", MonDReg, 32'hCAFEF00D);
    check("jrd_idle", 32'(dbg_state), 0);
    cpu_wr(9'h020, 32'h11223344, 4'b0101);
    cpu_rd_chk("rd_be", 9'h020, 32'hCA22F044);

    // address pointer wrap
    cpu_wr(9'h000, 32'h0000A5A5, 4'hF);
    cpu_wr(9'h0FF, 32'h5A5A0000, 4'hF);
    jtag_a(8'hFF, 1'b0);
    tick(); tick();
    check("wrap_rd_ff_a", MonDReg, 32'h5A5A0000);
    jtag_b(32'd0);
    tick(); tick();
    check("wrap_rd_ff_b", MonDReg, 32'h5A5A0000);
    jtag_b(32'd0);
    tick(); tick();
    check("wrap_rd_00", MonDReg, 32'h0000A5A5);

    // CPU read held across a JTAG read
    jdo = '0;
    jdo[JDO_ADDR_LSB +: 8] = 8'h10;
    take_action_ocimem_a = 1'b1;
    cpu_address = 9'h011;
    cpu_read = 1'b1;
    rdv_cnt = 0;
    #1;
    check("hold_wait_strobe", 32'(cpu_waitrequest), 1);
    tick();
    take_action_ocimem_a = 1'b0;
    rdv_cnt += int'(cpu_readdatavalid);
    check("hold_wait_jacc", 32'(cpu_waitrequest), 1);
    tick();
    rdv_cnt += int'(cpu_readdatavalid);
    check("hold_wait_jcap", 32'(cpu_waitrequest), 1);
    tick();
    rdv_cnt += int'(cpu_readdatavalid);
    check("hold_wait_idle", 32'(cpu_waitrequest), 0);
    check("hold_mondreg", MonDReg, 32'd1);
    tick();
    cpu_read = 1'b0;
    rdv_cnt += int'(cpu_readdatavalid);
    check("hold_rdata", cpu_readdata, 32'd2);
    tick();
    rdv_cnt += int'(cpu_readdatavalid);
    check("hold_rdv_once", rdv_cnt, 1);

    // three strobes back to back: two served, third dropped
    jtag_a(8'h10, 1'b0);
    jtag_a(8'h11, 1'b0);
    jtag_a(8'h12, 1'b0);
    check("ovf_first_served", MonDReg, 32'd1);
    tick(); tick();
    check("ovf_second_served", MonDReg, 32'd2);
    check("ovf_third_dropped", 32'(dbg_state), 0);
    tick(); tick();
    check("ovf_still_idle", 32'(dbg_state), 0);
    check("ovf_mondreg_hold", MonDReg, 32'd2);
    cpu_rd_chk("ovf_ctrl", 9'h100, 32'h8);

    // flag control and conflicts
    cpu_address = 9'h100;
    cpu_writedata = 32'h1;
    cpu_write = 1'b1;
    jdo = '0;
    jdo[JDO_GO] = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    tick();
    cpu_write = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    check("conf_ready", 32'(monitor_ready), 0);
    check("conf_go", 32'(monitor_go), 1);
    cpu_wr(9'h100, 32'h3, 4'hF);
    check("set_ready", 32'(monitor_ready), 1);
    check("set_error", 32'(monitor_error), 1);
    check("set_go_kept", 32'(monitor_go), 1);
    jtag_na(1'b0, 1'b1);
    check("clr_error", 32'(monitor_error), 0);
    check("clr_error_ready_kept", 32'(monitor_ready), 1);
    cpu_wr(9'h100, 32'h4, 4'hF);
    check("clr_go", 32'(monitor_go), 0);
    cpu_rd_chk("ctrl_rd", 9'h100, 32'h9);

    // write and read both high: write only
    cpu_address = 9'h030;
    cpu_writedata = 32'h12345678;
    cpu_byteenable = 4'hF;
    cpu_write = 1'b1;
    cpu_read = 1'b1;
    tick();
    cpu_write = 1'b0;
    cpu_read = 1'b0;
    check("wr_rd_no_rdv", 32'(cpu_readdatavalid), 0);
    cpu_rd_chk("wr_rd_data", 9'h030, 32'h12345678);

    // reset in the middle of a JTAG read
    jtag_a(8'h12, 1'b0);
    check("mid_jacc", 32'(dbg_state), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(dbg_state), 0);
    check("mid_rst_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 0);
    check("mid_rst_mondreg", MonDReg, 0);
    check("mid_rst_rdv", 32'(cpu_readdatavalid), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("mid_rst_after_state", 32'(dbg_state), 0);
    cpu_rd_chk("mid_rst_ctrl", 9'h100, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
